// File: rtl/qmca_readout_seq_if.sv
// Readout sequencer bus bundle: event FIFO read side plus USB byte port.
// master = sequencer, slave = FIFO/consumer side.
interface qmca_readout_seq_if;
  logic [14:0] evt_cnt_rd;
  logic        evt_empty;
  logic        evt_rd;
  logic [7:0]  evt_dout;
  logic        usb_rd;
  logic        usb_valid;
  logic [7:0]  usb_data;

  modport master (
    input  evt_cnt_rd,
    input  evt_empty,
    input  evt_dout,
    input  usb_rd,
    output evt_rd,
    output usb_valid,
    output usb_data
  );

  modport slave (
    output evt_cnt_rd,
    output evt_empty,
    output evt_dout,
    output usb_rd,
    input  evt_rd,
    input  usb_valid,
    input  usb_data
  );
endinterface

// File: rtl/qmca_readout_seq.sv
// Frame sequencer: waits for one full event in the FIFO, then emits a 4-byte header followed
// by the payload, streamed from a 2-entry prefetch buffer at one byte per cycle.
module qmca_readout_seq #(
  parameter logic [7:0] HDR_MAGIC = 8'hA5
) (
  input  logic                       bus_clk,
  input  logic                       bus_rst_n,
  input  logic                       conf_en,
  input  logic [11:0]                conf_evt_size,
  input  logic [1:0]                 conf_channel,
  input  logic                       err_clr,
  qmca_readout_seq_if.master         bus,
  output logic                       busy,
  output logic [15:0]                frame_cnt,
  output logic                       err_underrun
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StHdr,
    StData,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] size_q, size_d;
  logic [1:0]  ch_q, ch_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        err_q, err_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [14:0] pay_rem_q, pay_rem_d;
  logic [14:0] fetch_rem_q, fetch_rem_d;

  // Prefetch buffer: two-entry ring, plus one read in flight from the FIFO.
  logic [7:0]  buf_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  occ_q, occ_d;
  logic        inflight_q;

  logic [14:0] pay_bytes;
  logic        start_hdr;
  logic        pop;
  logic [1:0]  occ_avail;
  logic        fetch_rd;
  logic        underrun;
  logic        usb_valid;
  logic [7:0]  usb_data;
  logic [7:0]  hdr_byte;

  assign pay_bytes = {size_q, 3'b000};
  assign start_hdr = (state_q == StWait) && conf_en && (bus.evt_cnt_rd >= pay_bytes);
  assign pop       = (state_q == StData) && bus.usb_rd && (occ_q != 2'd0);

  // Count a slot as free when it is popped this cycle, so a pop and refill can overlap and
  // the payload sustains one byte per cycle.
  assign occ_avail = occ_q - {1'b0, pop};
  assign fetch_rd  = (fetch_rem_q != '0) && ((occ_avail + {1'b0, inflight_q}) < 2'd2) &&
                     !bus.evt_empty;
  assign underrun  = (fetch_rem_q != '0) && bus.evt_empty;

  always_comb begin
    hdr_byte = HDR_MAGIC;
    unique case (hdr_idx_q)
      2'd0:    hdr_byte = HDR_MAGIC;
      2'd1:    hdr_byte = {ch_q, 2'b00, size_q[11:8]};
      2'd2:    hdr_byte = size_q[7:0];
      default: hdr_byte = seq_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    ch_d        = ch_q;
    seq_d       = seq_q;
    frame_cnt_d = frame_cnt_q;
    hdr_idx_d   = hdr_idx_q;
    pay_rem_d   = pay_rem_q;
    usb_valid   = 1'b0;
    usb_data    = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (conf_en && (conf_evt_size != 12'd0)) begin
          state_d = StWait;
          size_d  = conf_evt_size;
          ch_d    = conf_channel;
        end
      end
      StWait: begin
        if (!conf_en) begin
          state_d = StIdle;
        end else if (start_hdr) begin
          state_d   = StHdr;
          hdr_idx_d = 2'd0;
          pay_rem_d = pay_bytes;
        end
      end
      StHdr: begin
        usb_valid = 1'b1;
        usb_data  = hdr_byte;
        if (bus.usb_rd) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'd3) begin
            state_d = StData;
          end
        end
      end
      StData: begin
        usb_valid = (occ_q != 2'd0);
        usb_data  = buf_q[rd_ptr_q];
        if (pop) begin
          pay_rem_d = pay_rem_q - 15'd1;
          if (pay_rem_q == 15'd1) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        seq_d       = seq_q + 8'd1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fetch_rem_d = fetch_rem_q;
    if (start_hdr) begin
      fetch_rem_d = pay_bytes;
    end else if (fetch_rd) begin
      fetch_rem_d = fetch_rem_q - 15'd1;
    end

    occ_d    = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    wr_ptr_d = wr_ptr_q ^ inflight_q;
    rd_ptr_d = rd_ptr_q ^ pop;

    // Set has priority over clear.
    err_d = err_q;
    if (underrun) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q     <= StIdle;
      size_q      <= '0;
      ch_q        <= '0;
      seq_q       <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      hdr_idx_q   <= '0;
      pay_rem_q   <= '0;
      fetch_rem_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      ch_q        <= ch_d;
      seq_q       <= seq_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      hdr_idx_q   <= hdr_idx_d;
      pay_rem_q   <= pay_rem_d;
      fetch_rem_q <= fetch_rem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      inflight_q  <= fetch_rd;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= bus.evt_dout;
      end
    end
  end

  assign bus.evt_rd    = fetch_rd;
  assign bus.usb_valid = usb_valid;
  assign bus.usb_data  = usb_data;
  assign busy          = (state_q != StIdle);
  assign frame_cnt     = frame_cnt_q;
  assign err_underrun  = err_q;

endmodule
